// File: rtl/instr_encoder_pkg.sv
// Shared encodings for the instruction encoder and field packer.
// Class codes, opcode prefixes, fixed words and FSM states.
package instr_encoder_pkg;

  typedef enum logic [3:0] {
    CLS_ALU  = 4'd0,
    CLS_MOVE = 4'd1,
    CLS_NOP  = 4'd2,
    CLS_HLT  = 4'd3,
    CLS_PUSH = 4'd4,
    CLS_POP  = 4'd5,
    CLS_CALL = 4'd6,
    CLS_RET  = 4'd7,
    CLS_JMP  = 4'd8
  } cls_e;

  localparam logic       OP_ALU   = 1'b1;
  localparam logic [1:0] OP_MOVE  = 2'b01;
  localparam logic [3:0] OP_SYS   = 4'b0000;
  localparam logic [3:0] OP_STACK = 4'b0001;
  localparam logic [3:0] OP_CALL  = 4'b0010;
  localparam logic [3:0] OP_JMP   = 4'b0011;

  localparam logic [15:0] W_NOP = {OP_SYS, 12'h000};
  localparam logic [15:0] W_HLT = {OP_SYS, 12'h200};
  localparam logic [15:0] W_RET = {OP_CALL, 12'h200};

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCEPT,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_e;

  typedef struct packed {
    logic [3:0] cls;
    logic [2:0] sub;
    logic [2:0] ra;
    logic [2:0] rb;
    logic [7:0] imm;
    logic       use_reg;
  } fields_t;

endpackage

// File: rtl/instr_encoder_pack.sv
// Combinational field packer: instruction fields to a 16-bit word.
// Flags unknown classes and reserved MOVE sub-ops as illegal.
module instr_pack
  import instr_encoder_pkg::*;
(
  input  fields_t     f,
  output logic [15:0] word,
  output logic        illegal
);

  logic [7:0] opnd;
  logic [7:0] rb_fld;

  assign rb_fld = {f.rb, 5'b00000};
  assign opnd   = f.use_reg ? rb_fld : f.imm;

  always_comb begin
    word    = '0;
    illegal = 1'b0;
    unique case (1'b1)
      f.cls == CLS_ALU:
        word = {OP_ALU, f.use_reg, f.sub, f.ra, opnd};
      f.cls == CLS_MOVE: begin
        // odd sub-ops carry a register, even ones an immediate
        illegal = (f.sub == 3'b100) || (f.sub == 3'b101);
        word    = {OP_MOVE, f.sub, f.ra,
                   f.sub[0] ? rb_fld : f.imm};
      end
      f.cls == CLS_NOP:
        word = W_NOP;
      f.cls == CLS_HLT:
        word = W_HLT;
      f.cls == CLS_PUSH:
        word = {OP_STACK, 3'b000, f.use_reg, opnd};
      f.cls == CLS_POP:
        word = {OP_STACK, 3'b001, 1'b0, rb_fld};
      f.cls == CLS_CALL:
        word = {OP_CALL, 3'b000, f.use_reg, opnd};
      f.cls == CLS_RET:
        word = W_RET;
      f.cls == CLS_JMP:
        word = {OP_JMP, f.sub, f.use_reg, opnd};
      default:
        illegal = 1'b1;
    endcase
    if (illegal) word = '0;
  end

endmodule

// File: rtl/instr_encoder.sv
// Program loader: accepts instruction fields, encodes them and
// writes each word to instruction memory with an ack handshake.
module instr_encoder
  import instr_encoder_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  base_addr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  cls,
  input  logic [2:0]  sub,
  input  logic [2:0]  ra,
  input  logic [2:0]  rb,
  input  logic [7:0]  imm,
  input  logic        use_reg,
  output logic        im_we,
  input  logic        im_ack,
  output logic [7:0]  im_addr,
  output logic [15:0] im_wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [8:0]  count
);

  state_e      state;
  state_e      nxt;
  fields_t     f;
  logic [15:0] word;
  logic        illegal;
  logic [7:0]  ptr;
  logic [15:0] wdata;
  logic [8:0]  cnt;
  logic        err_q;

  assign f = '{cls: cls, sub: sub, ra: ra, rb: rb,
               imm: imm, use_reg: use_reg};

  instr_pack u_pack (
    .f       (f),
    .word    (word),
    .illegal (illegal)
  );

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:
        if (start) nxt = S_ACCEPT;
      S_ACCEPT:
        if (in_valid) nxt = illegal ? S_ERR : S_WRITE;
      S_WRITE:
        if (im_ack) begin
          if (wdata == W_HLT)    nxt = S_DONE;
          else if (ptr == 8'hFF) nxt = S_ERR;
          else                   nxt = S_ACCEPT;
        end
      S_DONE:  nxt = S_IDLE;
      S_ERR:   nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      ptr   <= '0;
      wdata <= '0;
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      state <= nxt;
      if (state == S_IDLE && start) begin
        ptr   <= base_addr;
        cnt   <= '0;
        err_q <= 1'b0;
      end
      if (state == S_ACCEPT && in_valid && !illegal)
        wdata <= word;
      if (state == S_WRITE && im_ack) begin
        cnt <= cnt + 9'd1;
        ptr <= ptr + 8'd1;
      end
      if (nxt == S_ERR) err_q <= 1'b1;
    end
  end

  assign in_ready = (state == S_ACCEPT);
  assign im_we    = (state == S_WRITE);
  assign busy     = (state == S_ACCEPT) || (state == S_WRITE);
  assign done     = (state == S_DONE);
  assign err      = err_q;
  assign im_addr  = ptr;
  assign im_wdata = wdata;
  assign count    = cnt;

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset, with ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- start  in  1  begin a program load at base_addr
- base_addr  in  8  first instruction-memory address
- in_valid  in  1  instruction fields valid
- in_ready  out  1  encoder can accept fields
- cls  in  4  instruction class: ALU, MOVE, NOP, HLT, PUSH, POP, CALL, RET, JMP
- sub  in  3  a_op / move sub-op / j_op
- ra  in  3  register in bits [10:8]
- rb  in  3  register in bits [7:5]
- imm  in  8  immediate in bits [7:0]
- use_reg  in  1  register operand form (1) or immediate form (0)
- im_we  out  1  instruction-memory write request
- im_ack  in  1  memory accepted the write
- im_addr  out  8  write address
- im_wdata  out  16  encoded instruction word
- busy  out  1  load in progress
- done  out  1  one-cycle pulse at normal completion
- err  out  1  sticky error flag
- count  out  9  words written in the current load

Function
REQ-002 Encoding SHALL follow these rules; every unlisted bit SHALL be 0.
- ALU: [15]=1, [14]=use_reg, [13:11]=sub, [10:8]=ra; [7:5]=rb if use_reg, else [7:0]=imm.
- MOVE: [15:14]=01, [13:11]=sub, [10:8]=ra; sub 001/011/111 put rb in [7:5]; sub 000/010/110 put imm in [7:0].
- NOP = 0x0000; HLT = 0x0200.
- PUSH: [15:12]=0001, [11:9]=000, [8]=use_reg, rb or imm as for ALU.
- POP: [15:12]=0001, [11:9]=001, [7:5]=rb.
- CALL: [15:12]=0010, [11:9]=000, [8]=use_reg, rb or imm.
- RET = 0x2200.
- JMP: [15:12]=0011, [11:9]=sub, [8]=use_reg, rb or imm.
REQ-003 The FSM SHALL have states IDLE, ACCEPT, WRITE, DONE and ERR.
REQ-004 In IDLE, start SHALL load the address pointer from base_addr, clear count and err, and go to ACCEPT.
REQ-005 start SHALL be ignored in ACCEPT, WRITE and DONE.
REQ-006 in_ready SHALL be 1 only in ACCEPT.
REQ-007 A transfer SHALL occur on an edge where in_valid and in_ready are both 1; the encoded word SHALL be registered and the FSM SHALL go to WRITE.
REQ-008 im_we SHALL be asserted the cycle after the transfer (1-cycle latency).
REQ-009 im_we, im_addr and im_wdata SHALL be held stable until im_ack is sampled high.
REQ-010 A write SHALL complete on the edge where im_we and im_ack are both 1; on that edge count SHALL increment and the address pointer SHALL increment mod 256.
REQ-011 After a completed write, the next state SHALL be DONE if the word was HLT, otherwise ERR if the written address was 0xFF, otherwise ACCEPT.
REQ-012 im_ack while im_we=0 SHALL be ignored.
REQ-013 An illegal input SHALL go to ERR with no memory write. Illegal means a MOVE sub of 100 or 101, or a cls code outside the defined set.
REQ-014 DONE SHALL last one cycle with done=1, then go to IDLE.
REQ-015 ERR SHALL hold err=1 and return to IDLE on the next cycle. err SHALL stay set until the next accepted start.
REQ-016 busy SHALL be 1 in ACCEPT and WRITE.

Reset
REQ-017 While rst_n=0 at a clock edge, the block SHALL enter IDLE with in_ready, im_we, busy, done and err = 0, im_addr = 0x00, im_wdata = 0x0000 and count = 0.
REQ-018 A reset during WRITE SHALL drop im_we at that edge, and no count increment SHALL occur.

Structure
REQ-019 The cls codes, the top-level opcode prefixes (ALU, MOVE, SYS, STACK, CALL, JMP) and the HLT/RET/NOP constants SHALL live in a shared package that is also used by the decoder.
REQ-020 Field packing SHALL be one combinational sub-module, instr_pack (fields in -> 16-bit word plus illegal flag out). The FSM, pointer and counter SHALL stay in instr_encoder.

Verification
REQ-021 ALU, use_reg=1, sub=001, ra=2, rb=3 -> im_wdata=0xCA60, im_we one cycle after the transfer.
REQ-022 MOVE sub=000, ra=5, imm=0x3C, then HLT, with base_addr=0x10 -> writes 0x453C@0x10 and 0x0200@0x11, done pulse, count=2.
REQ-023 im_ack held low for 3 cycles -> im_we, im_addr and im_wdata stable throughout, in_ready=0; JMP sub=010, imm=0x20 -> 0x3420.
REQ-024 PUSH rb=4 reg, POP rb=2, RET -> 0x1180, 0x1240, 0x2200.
REQ-025 base_addr=0xFF, one non-HLT word -> write at 0xFF, then err=1 and return to IDLE; MOVE sub=100 -> err=1 with no im_we.
REQ-026 rst_n low during WRITE -> im_we=0, count=0, IDLE on the next edge.
